// File: rtl/fft_tw_addr_sequencer.sv
// fft_tw_addr_sequencer
//
// Address sequencer for a sequential decimation-in-frequency FFT of
// N = 2^SIZE points. It walks all SIZE stages and all N/2 butterflies per
// stage, one butterfly per cycle. For every butterfly it issues a twiddle
// read: the enable and the exponent k of W_N^k. It also raises a valid strobe
// that lines up with the generator's one-cycle read latency.
//
// Parameters
//   SIZE     log2 of the FFT length, legal range 2..12
//   ANGLE_W  width of rd_ptr_angle, 11 to match the twiddle generator
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         request a full FFT sequence (sampled only when idle)
//   stall         back-pressure; no new address is issued while high
//   en_rd         twiddle read enable, one per issued butterfly
//   rd_ptr_angle  twiddle exponent k, zero-extended
//   stage         stage index of the issue, aligned with tw_valid
//   bfly_idx      butterfly index j of the issue, aligned with tw_valid
//   last_bfly     final butterfly of a stage, aligned with tw_valid
//   tw_valid      en_rd delayed one cycle (twiddle cos/sin valid)
//   busy          high from accepted start until done
//   done          one-cycle pulse at sequence completion

module fft_tw_addr_sequencer #(
  parameter int SIZE    = 10,
  parameter int ANGLE_W = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  output logic               en_rd,
  output logic [ANGLE_W-1:0] rd_ptr_angle,
  output logic [3:0]         stage,
  output logic [SIZE-2:0]    bfly_idx,
  output logic               last_bfly,
  output logic               tw_valid,
  output logic               busy,
  output logic               done
);

  localparam int JW = SIZE - 1;

  // j runs 0..N/2-1, so its last value is the all-ones pattern of JW bits.
  localparam logic [JW-1:0] J_LAST     = '1;
  localparam logic [3:0]    STAGE_LAST = 4'(SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      stage_q, stage_d;
  logic [JW-1:0]   j_q, j_d;
  logic [JW-1:0]   k_q, k_d;
  logic            stage_end;

  // An issue happens in every RUN cycle that downstream does not stall.
  assign en_rd     = (state_q == S_RUN) && !stall;
  assign stage_end = (j_q == J_LAST);
  assign busy      = (state_q != S_IDLE);

  // k < N/2 always fits in JW bits; the upper bits of the pointer stay zero.
  assign rd_ptr_angle = ANGLE_W'(k_q);

  // Next-state and counter logic. The counters move only on an issue. After
  // the final issue they return to zero, which leaves the block idle with the
  // first address of the next run already presented.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    j_d     = j_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          stage_d = '0;
          j_d     = '0;
        end
      end
      S_RUN: begin
        if (en_rd) begin
          if (stage_end) begin
            j_d = '0;
            if (stage_q == STAGE_LAST) begin
              stage_d = '0;
              state_d = S_FLUSH;
            end else begin
              stage_d = stage_q + 4'd1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // k = (j mod (N >> (s+1))) << s. The modulus is a power of two, so it is a
  // mask of the low JW-s bits of j. The mask is the all-ones j pattern shifted
  // right by s. The product by 2^s is a plain left shift, so no multiplier is
  // needed. The mask keeps the shifted value inside JW bits.
  always_comb begin
    k_d = (j_d & (J_LAST >> stage_d)) << stage_d;
  end

  // State, counters and the registered twiddle exponent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // Outputs delayed by one cycle so they line up with the twiddle data.
  // stage and bfly_idx keep the last issued values between issues.
  // done is registered off FLUSH, so busy and done change in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_valid  <= 1'b0;
      last_bfly <= 1'b0;
      stage     <= '0;
      bfly_idx  <= '0;
      done      <= 1'b0;
    end else begin
      tw_valid  <= en_rd;
      last_bfly <= en_rd && stage_end;
      done      <= (state_q == S_FLUSH);
      if (en_rd) begin
        stage    <= stage_q;
        bfly_idx <= j_q;
      end
    end
  end

endmodule

// File: tb/tb_fft_tw_addr_sequencer.sv
// Testbench for fft_tw_addr_sequencer.
// Instance a uses SIZE=3 and covers the cycle-level behaviour:
//   - a fixed vector table
//   - stalls, including random stalls
//   - ignored starts and back-to-back runs
//   - reset in the middle of a run
// Instance b uses SIZE=10 and covers one full-length unstalled run.

module tb_fft_tw_addr_sequencer;

  localparam int A_SIZE = 3;
  localparam int A_HALF = (1 << A_SIZE) / 2;
  localparam int A_M    = A_SIZE * A_HALF;
  localparam int B_SIZE = 10;
  localparam int B_HALF = (1 << B_SIZE) / 2;
  localparam int B_M    = B_SIZE * B_HALF;

  logic clk;
  logic rst_n;
  logic a_start, a_stall, b_start, b_stall;

  logic        a_en_rd, a_last_bfly, a_tw_valid, a_busy, a_done;
  logic [10:0] a_rd_ptr_angle;
  logic [3:0]  a_stage;
  logic [1:0]  a_bfly_idx;

  logic        b_en_rd, b_last_bfly, b_tw_valid, b_busy, b_done;
  logic [10:0] b_rd_ptr_angle;
  logic [3:0]  b_stage;
  logic [8:0]  b_bfly_idx;

  int tests_run = 0;
  int fail_cnt  = 0;

  fft_tw_addr_sequencer #(.SIZE(A_SIZE), .ANGLE_W(11)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stall(a_stall),
    .en_rd(a_en_rd), .rd_ptr_angle(a_rd_ptr_angle), .stage(a_stage),
    .bfly_idx(a_bfly_idx), .last_bfly(a_last_bfly), .tw_valid(a_tw_valid),
    .busy(a_busy), .done(a_done)
  );

  fft_tw_addr_sequencer #(.SIZE(B_SIZE), .ANGLE_W(11)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stall(b_stall),
    .en_rd(b_en_rd), .rd_ptr_angle(b_rd_ptr_angle), .stage(b_stage),
    .bfly_idx(b_bfly_idx), .last_bfly(b_last_bfly), .tw_valid(b_tw_valid),
    .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference twiddle exponent from the FFT definition.
  function automatic int expAngle(input int size, input int s, input int j);
    return (j % ((1 << size) >> (s + 1))) * (1 << s);
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests_run++;
    if (actual != expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive inputs just after a rising edge, then move to the falling edge for sampling.
  task automatic applyStimulus(input logic st, input logic sv);
    @(posedge clk);
    #1;
    a_start = st;
    a_stall = sv;
    @(negedge clk);
  endtask

  typedef struct {
    logic start;
    logic stall;
    logic en;
    int   angle;
    logic tv;
    int   stg;
    int   bf;
    logic last;
    logic busy;
    logic done;
  } vec_t;

  function automatic vec_t mkVec(input logic st, input logic sv, input logic en, input int ang,
                                 input logic tv, input int stg, input int bf, input logic last,
                                 input logic bsy, input logic dn);
    vec_t v;
    v.start = st; v.stall = sv; v.en = en; v.angle = ang; v.tv = tv;
    v.stg = stg; v.bf = bf; v.last = last; v.busy = bsy; v.done = dn;
    return v;
  endfunction

  // Run one SIZE=3 sequence against the reference model.
  //   mode      0 = no stall, 1 = random stall, 2 = stall 3 cycles at issue 5
  //   mid_start pulse start again while busy
  //   chain_in  start was already accepted on the previous done cycle
  //   chain_out raise start in the done cycle
  task automatic runModel(input int mode, input bit mid_start, input bit chain_in,
                          input bit chain_out, input string tag);
    int issued, cyc, final_cyc, last_idx, stall_left;
    bit prev_en, exp_en, st, sv, running, exp_busy, exp_done;
    issued = 0; final_cyc = -1; last_idx = 0; stall_left = 3; prev_en = 0;
    cyc = chain_in ? 1 : 0;
    forever begin
      if (cyc > 400) begin
        fail_cnt++;
        $display("[TB] FAIL %s_timeout: got no done, expected done within 400 cycles", tag);
        break;
      end
      running = (cyc >= 1) && (issued < A_M);
      sv = 1'b0;
      if (running && mode == 1) sv = ($urandom % 3 == 0);
      if (running && mode == 2 && issued == 4 && stall_left > 0) begin
        sv = 1'b1;
        stall_left--;
      end
      st = (cyc == 0) || (mid_start && cyc == 5) ||
           (chain_out && final_cyc >= 0 && cyc == final_cyc + 2);
      applyStimulus(st, sv);
      exp_en = running && !sv;
      checkOutput($sformatf("%s_c%0d_en_rd", tag, cyc), a_en_rd, exp_en);
      checkOutput($sformatf("%s_c%0d_tw_valid", tag, cyc), a_tw_valid, prev_en);
      if (prev_en) begin
        checkOutput($sformatf("%s_c%0d_stage", tag, cyc), a_stage, last_idx / A_HALF);
        checkOutput($sformatf("%s_c%0d_bfly", tag, cyc), a_bfly_idx, last_idx % A_HALF);
        checkOutput($sformatf("%s_c%0d_last", tag, cyc), a_last_bfly,
                    (last_idx % A_HALF) == A_HALF - 1);
      end
      if (running) begin
        checkOutput($sformatf("%s_c%0d_angle", tag, cyc), a_rd_ptr_angle,
                    expAngle(A_SIZE, issued / A_HALF, issued % A_HALF));
      end
      if (exp_en) begin
        last_idx = issued;
        issued++;
        if (issued == A_M) final_cyc = cyc;
      end
      exp_busy = (cyc >= 1) && (final_cyc < 0 || cyc <= final_cyc + 1);
      exp_done = (final_cyc >= 0) && (cyc == final_cyc + 2);
      checkOutput($sformatf("%s_c%0d_busy", tag, cyc), a_busy, exp_busy);
      checkOutput($sformatf("%s_c%0d_done", tag, cyc), a_done, exp_done);
      prev_en = exp_en;
      if (exp_done) break;
      cyc++;
    end
  endtask

  initial begin
    vec_t tbl[16];
    int   issues, b_issued, b_tv, b_done_cnt, b_done_cyc, b_kerr, b_iderr, b_prev;

    tbl[0]  = mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkVec(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mkVec(0, 0, 1, 1, 1, 0, 0, 0, 1, 0);
    tbl[3]  = mkVec(0, 0, 1, 2, 1, 0, 1, 0, 1, 0);
    tbl[4]  = mkVec(0, 0, 1, 3, 1, 0, 2, 0, 1, 0);
    tbl[5]  = mkVec(0, 0, 1, 0, 1, 0, 3, 1, 1, 0);
    tbl[6]  = mkVec(0, 0, 1, 2, 1, 1, 0, 0, 1, 0);
    tbl[7]  = mkVec(0, 0, 1, 0, 1, 1, 1, 0, 1, 0);
    tbl[8]  = mkVec(0, 0, 1, 2, 1, 1, 2, 0, 1, 0);
    tbl[9]  = mkVec(0, 0, 1, 0, 1, 1, 3, 1, 1, 0);
    tbl[10] = mkVec(0, 0, 1, 0, 1, 2, 0, 0, 1, 0);
    tbl[11] = mkVec(0, 0, 1, 0, 1, 2, 1, 0, 1, 0);
    tbl[12] = mkVec(0, 0, 1, 0, 1, 2, 2, 0, 1, 0);
    tbl[13] = mkVec(0, 0, 0, 0, 1, 2, 3, 1, 1, 0);
    tbl[14] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[15] = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst_n = 1'b0; a_start = 1'b0; a_stall = 1'b0; b_start = 1'b0; b_stall = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_en_rd", a_en_rd, 0);
    checkOutput("reset_angle", a_rd_ptr_angle, 0);
    checkOutput("reset_stage", a_stage, 0);
    checkOutput("reset_bfly", a_bfly_idx, 0);
    checkOutput("reset_last", a_last_bfly, 0);
    checkOutput("reset_tw_valid", a_tw_valid, 0);
    checkOutput("reset_busy", a_busy, 0);
    checkOutput("reset_done", a_done, 0);
    rst_n = 1'b1;

    // Pass 0 is a plain run. Pass 1 repeats it with an extra start while busy.
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < 16; r++) begin
        applyStimulus(tbl[r].start | (p == 1 && r == 6), tbl[r].stall);
        checkOutput($sformatf("tbl_p%0d_r%0d_en_rd", p, r), a_en_rd, tbl[r].en);
        checkOutput($sformatf("tbl_p%0d_r%0d_tw_valid", p, r), a_tw_valid, tbl[r].tv);
        checkOutput($sformatf("tbl_p%0d_r%0d_last", p, r), a_last_bfly, tbl[r].last);
        checkOutput($sformatf("tbl_p%0d_r%0d_busy", p, r), a_busy, tbl[r].busy);
        checkOutput($sformatf("tbl_p%0d_r%0d_done", p, r), a_done, tbl[r].done);
        if (tbl[r].en)
          checkOutput($sformatf("tbl_p%0d_r%0d_angle", p, r), a_rd_ptr_angle, tbl[r].angle);
        if (tbl[r].tv) begin
          checkOutput($sformatf("tbl_p%0d_r%0d_stage", p, r), a_stage, tbl[r].stg);
          checkOutput($sformatf("tbl_p%0d_r%0d_bfly", p, r), a_bfly_idx, tbl[r].bf);
        end
      end
    end

    runModel(2, 1'b0, 1'b0, 1'b0, "stall5");
    runModel(1, 1'b0, 1'b0, 1'b0, "rand0");
    runModel(1, 1'b1, 1'b0, 1'b0, "rand1");
    runModel(1, 1'b0, 1'b0, 1'b0, "rand2");
    runModel(0, 1'b0, 1'b0, 1'b1, "b2b_first");
    runModel(0, 1'b0, 1'b1, 1'b0, "b2b_second");

    // Reset asserted while issue 7 is presented.
    issues = 0;
    applyStimulus(1'b1, 1'b0);
    for (int c = 0; c < 20 && issues < 7; c++) begin
      applyStimulus(1'b0, 1'b0);
      if (a_en_rd) issues++;
    end
    checkOutput("rst_mid_issues_before", issues, 7);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_en_rd", a_en_rd, 0);
    checkOutput("rst_mid_angle", a_rd_ptr_angle, 0);
    checkOutput("rst_mid_stage", a_stage, 0);
    checkOutput("rst_mid_bfly", a_bfly_idx, 0);
    checkOutput("rst_mid_last", a_last_bfly, 0);
    checkOutput("rst_mid_tw_valid", a_tw_valid, 0);
    checkOutput("rst_mid_busy", a_busy, 0);
    checkOutput("rst_mid_done", a_done, 0);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("rst_hold_c%0d_done", c), a_done, 0);
    end
    rst_n = 1'b1;
    runModel(0, 1'b0, 1'b0, 1'b0, "after_rst");

    // Full-length SIZE=10 run on instance b.
    b_issued = 0; b_tv = 0; b_done_cnt = 0; b_done_cyc = -1; b_kerr = 0; b_iderr = 0; b_prev = 0;
    for (int cyc = 0; cyc < B_M + 10; cyc++) begin
      @(posedge clk);
      #1;
      b_start = (cyc == 0);
      @(negedge clk);
      if (b_tw_valid) begin
        b_tv++;
        if (b_stage != 4'(b_prev / B_HALF) || b_bfly_idx != 9'(b_prev % B_HALF)) b_iderr++;
      end
      if (b_en_rd) begin
        if (b_rd_ptr_angle != 11'(expAngle(B_SIZE, b_issued / B_HALF, b_issued % B_HALF)))
          b_kerr++;
        b_prev = b_issued;
        b_issued++;
      end
      if (b_done) begin
        b_done_cnt++;
        b_done_cyc = cyc;
      end
    end
    checkOutput("b_issue_count", b_issued, B_M);
    checkOutput("b_tw_valid_count", b_tv, B_M);
    checkOutput("b_angle_errors", b_kerr, 0);
    checkOutput("b_index_errors", b_iderr, 0);
    checkOutput("b_done_count", b_done_cnt, 1);
    checkOutput("b_done_cycle", b_done_cyc, B_M + 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
